spmm_rhs_buffer: RTL and testbench

//  Ping-pong RHS matrix store feeding the PE lanes of the SpMM engine.
//  - Accepts a dense N x N RHS matrix B over the rhs_* beat interface, four rows per beat.
//  - Serves per-lane gathered operands rhs[i] = B[rd_row[i]][rd_col] to the multiplier lanes.
//  - Two banks: the next matrix loads while the current one is read.
//  - Weight-stationary reuse: a bank is retained across uses while keep is held.

---
 rtl/spmm_rhs_buffer.sv | 146 ++++++++++++++
 tb/tb_spmm_rhs_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmm_rhs_buffer.sv
// spmm_rhs_buffer: two-bank (ping-pong) store for the dense RHS matrix of the
// SpMM engine. One bank loads, RPB rows per beat, while the other bank serves
// per-lane gathered reads. A full bank can be kept across several uses
// (weight-stationary) or released so that it can be loaded again.
module spmm_rhs_buffer #(
  parameter int N   = 16,
  parameter int W   = 8,
  parameter int RPB = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       rhs_ready,
  input  logic                       rhs_start,
  input  logic [RPB*N*W-1:0]         rhs_data,
  output logic                       bank_valid,
  input  logic                       rd_en,
  input  logic [N*$clog2(N)-1:0]     rd_row,
  input  logic [$clog2(N)-1:0]       rd_col,
  output logic                       rd_valid,
  output logic [N*W-1:0]             rd_data,
  input  logic                       done,
  input  logic                       keep
);

  localparam int LGN = $clog2(N);
  localparam int NB  = N / RPB;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t          bank_state_r [2];
  bank_state_t          bank_state_next_s [2];
  logic                 wr_bank_r, wr_bank_next_s;
  logic                 rd_bank_r, rd_bank_next_s;
  logic [BCW-1:0]       beat_cnt_r, beat_cnt_next_s;

  logic                 rhs_ready_s;
  logic                 bank_valid_s;
  logic                 accept_s;
  logic                 last_beat_s;
  logic                 release_s;
  logic [LGN-1:0]       row_base_s;

  // Storage carries no reset: contents are only exposed once a bank is FULL.
  logic [W-1:0]         mem_r [2][N][N];

  logic                 rd_valid_r;
  logic [N*W-1:0]       rd_data_r;

  // Write side may accept a beat while its bank is not yet complete.
  always_comb begin
    rhs_ready_s = 1'b0;
    case (bank_state_r[wr_bank_r])
      EMPTY, LOADING: rhs_ready_s = 1'b1;
      default:        rhs_ready_s = 1'b0;
    endcase
  end

  assign bank_valid_s = (bank_state_r[rd_bank_r] == FULL);
  assign accept_s     = rhs_start && rhs_ready_s;
  assign last_beat_s  = accept_s && (beat_cnt_r == BCW'(NB - 1));
  assign release_s    = done && bank_valid_s && !keep;
  assign row_base_s   = LGN'(beat_cnt_r * RPB);

  // Next-state logic for bank states, bank pointers and the beat counter.
  // A load and a release never target the same bank: loading needs a
  // non-FULL write bank, releasing needs a FULL read bank.
  always_comb begin
    bank_state_next_s[0] = bank_state_r[0];
    bank_state_next_s[1] = bank_state_r[1];
    wr_bank_next_s       = wr_bank_r;
    rd_bank_next_s       = rd_bank_r;
    beat_cnt_next_s      = beat_cnt_r;
    if (accept_s) begin
      if (last_beat_s) begin
        bank_state_next_s[wr_bank_r] = FULL;
        wr_bank_next_s               = ~wr_bank_r;
        beat_cnt_next_s              = {BCW{1'b0}};
      end else begin
        bank_state_next_s[wr_bank_r] = LOADING;
        beat_cnt_next_s              = beat_cnt_r + BCW'(1);
      end
    end else begin
      beat_cnt_next_s = beat_cnt_r;
    end
    if (release_s) begin
      bank_state_next_s[rd_bank_r] = EMPTY;
      rd_bank_next_s               = ~rd_bank_r;
    end else begin
      rd_bank_next_s = rd_bank_r;
    end
  end

  // Control state register; reset discards any partially loaded matrix.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_state_r[0] <= EMPTY;
      bank_state_r[1] <= EMPTY;
      wr_bank_r       <= 1'b0;
      rd_bank_r       <= 1'b0;
      beat_cnt_r      <= {BCW{1'b0}};
    end else begin
      bank_state_r[0] <= bank_state_next_s[0];
      bank_state_r[1] <= bank_state_next_s[1];
      wr_bank_r       <= wr_bank_next_s;
      rd_bank_r       <= rd_bank_next_s;
      beat_cnt_r      <= beat_cnt_next_s;
    end
  end

  // Write the RPB rows of an accepted beat into the loading bank.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      for (int r = 0; r < RPB; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_r[wr_bank_r][row_base_s + LGN'(r)][LGN'(c)] <= rhs_data[(r*N + c)*W +: W];
        end
      end
    end
  end

  // Gather one element per lane from the read bank; data holds when no read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {(N*W){1'b0}};
    end else if (rd_en && bank_valid_s) begin
      rd_valid_r <= 1'b1;
      for (int i = 0; i < N; i++) begin
        rd_data_r[i*W +: W] <= mem_r[rd_bank_r][rd_row[i*LGN +: LGN]][rd_col];
      end
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rhs_ready  = rhs_ready_s;
  assign bank_valid = bank_valid_s;
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_spmm_rhs_buffer.sv
// tb_spmm_rhs_buffer: directed scenarios plus a randomized phase, checked
// against a model that sees the buffer as a queue of complete matrices
// (at most two) plus one partially received matrix.
module tb_spmm_rhs_buffer;

  localparam int N   = 16;
  localparam int W   = 8;
  localparam int RPB = 4;
  localparam int LGN = 4;
  localparam int NB  = N / RPB;

  typedef logic [N*N*W-1:0] mat_t;

  logic                 clock;
  logic                 reset;
  logic                 rhs_ready;
  logic                 rhs_start;
  logic [RPB*N*W-1:0]   rhs_data;
  logic                 bank_valid;
  logic                 rd_en;
  logic [N*LGN-1:0]     rd_row;
  logic [LGN-1:0]       rd_col;
  logic                 rd_valid;
  logic [N*W-1:0]       rd_data;
  logic                 done;
  logic                 keep;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  mat_t                 full_q[$];
  mat_t                 part_m;
  int                   part_cnt;
  logic                 exp_rv;
  logic [N*W-1:0]       exp_rd;

  spmm_rhs_buffer #(.N(N), .W(W), .RPB(RPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .rhs_ready  (rhs_ready),
    .rhs_start  (rhs_start),
    .rhs_data   (rhs_data),
    .bank_valid (bank_valid),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .done       (done),
    .keep       (keep)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] elem(input mat_t m, input int r, input int c);
    return m[(r*N + c)*W +: W];
  endfunction

  // kind 0: 16r+c, 1: r+c, 2: 255-r, otherwise random
  function automatic mat_t mk(input int kind);
    mat_t m;
    int   v;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (kind)
          0:       v = r*16 + c;
          1:       v = r + c;
          2:       v = 255 - r;
          default: v = int'($urandom_range(0, 255));
        endcase
        m[(r*N + c)*W +: W] = W'(v);
      end
    end
    return m;
  endfunction

  function automatic logic [RPB*N*W-1:0] beat_of(input mat_t m, input int b);
    logic [RPB*N*W-1:0] d;
    for (int r = 0; r < RPB; r++) begin
      for (int c = 0; c < N; c++) begin
        d[(r*N + c)*W +: W] = elem(m, RPB*b + r, c);
      end
    end
    return d;
  endfunction

  task automatic clear_inputs();
    rhs_start = 1'b0;
    rd_en     = 1'b0;
    done      = 1'b0;
    keep      = 1'b0;
  endtask

  task automatic rand_read();
    rd_en = 1'b1;
    for (int i = 0; i < N; i++) rd_row[i*LGN +: LGN] = LGN'($urandom_range(0, N-1));
    rd_col = LGN'($urandom_range(0, N-1));
  endtask

  // One clock cycle with the inputs already driven: check the handshake
  // outputs mid-cycle, advance the model, then check the read result.
  task automatic tick();
    logic m_ready;
    logic m_valid;
    m_ready = (full_q.size() < 2);
    m_valid = (full_q.size() > 0);
    @(negedge clock);
    check_eq("rhs_ready", {127'd0, rhs_ready}, {127'd0, m_ready});
    check_eq("bank_valid", {127'd0, bank_valid}, {127'd0, m_valid});
    if (rd_en && m_valid) begin
      exp_rv = 1'b1;
      for (int i = 0; i < N; i++) begin
        exp_rd[i*W +: W] = elem(full_q[0], int'(rd_row[i*LGN +: LGN]), int'(rd_col));
      end
    end else begin
      exp_rv = 1'b0;
    end
    if (done && m_valid && !keep) void'(full_q.pop_front());
    if (rhs_start && m_ready) begin
      for (int r = 0; r < RPB; r++) begin
        for (int c = 0; c < N; c++) begin
          part_m[((RPB*part_cnt + r)*N + c)*W +: W] = rhs_data[(r*N + c)*W +: W];
        end
      end
      part_cnt++;
      if (part_cnt == NB) begin
        full_q.push_back(part_m);
        part_cnt = 0;
      end
    end
    @(posedge clock);
    #1;
    check_eq("rd_valid", {127'd0, rd_valid}, {127'd0, exp_rv});
    check_eq("rd_data", rd_data, exp_rd);
    clear_inputs();
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    check_eq("rst_rhs_ready", {127'd0, rhs_ready}, 128'd1);
    check_eq("rst_bank_valid", {127'd0, bank_valid}, 128'd0);
    check_eq("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
    check_eq("rst_rd_data", rd_data, 128'd0);
    full_q.delete();
    part_cnt = 0;
    exp_rv   = 1'b0;
    exp_rd   = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic load(input mat_t m, input int first, input int last, input bit reads);
    for (int b = first; b <= last; b++) begin
      rhs_start = 1'b1;
      rhs_data  = beat_of(m, b);
      if (reads) rand_read();
      tick();
    end
  endtask

  initial begin
    mat_t a;
    mat_t b2;
    logic [W-1:0] lane_v;
    reset    = 1'b0;
    rhs_data = '0;
    rd_row   = '0;
    rd_col   = '0;
    part_m   = '0;
    clear_inputs();
    apply_reset();

    // 1: load 16r+c, gather rows 0..15 of column 3
    load(mk(0), 0, NB-1, 1'b0);
    rd_en = 1'b1;
    for (int i = 0; i < N; i++) rd_row[i*LGN +: LGN] = LGN'(i);
    rd_col = 4'd3;
    tick();
    lane_v = rd_data[5*W +: W];
    check_eq("t1_lane5", {120'd0, lane_v}, 128'd83);

    // 2: load A while idle, load B2 during reads of A, then release A
    apply_reset();
    a  = mk(1);
    b2 = mk(2);
    load(a, 0, NB-1, 1'b0);
    load(b2, 0, NB-1, 1'b1);
    rand_read();
    tick();
    done = 1'b1;
    rand_read();
    tick();
    rd_en = 1'b1;
    rd_row[0 +: LGN] = 4'd7;
    tick();
    lane_v = rd_data[0 +: W];
    check_eq("t2_lane0", {120'd0, lane_v}, 128'd248);

    // 3: keep the bank three times, then read rows 15-i of column 0
    apply_reset();
    load(a, 0, NB-1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      done = 1'b1;
      keep = 1'b1;
      rand_read();
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < N; i++) rd_row[i*LGN +: LGN] = LGN'(15 - i);
    rd_col = 4'd0;
    tick();
    lane_v = rd_data[2*W +: W];
    check_eq("t3_lane2", {120'd0, lane_v}, 128'd13);

    // 4: reset in the middle of a load, then a fresh load
    load(mk(3), 0, 1, 1'b0);
    apply_reset();
    load(mk(0), 0, NB-1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rand_read();
      tick();
    end

    // 5: read with no bank holds data; beats while both banks full are ignored
    done = 1'b1;
    tick();
    rand_read();
    tick();
    load(mk(1), 0, NB-1, 1'b0);
    load(mk(2), 0, NB-1, 1'b0);
    load(mk(3), 0, NB-1, 1'b1);
    done = 1'b1;
    tick();
    rand_read();
    tick();
    load(mk(0), 0, NB-1, 1'b1);
    done = 1'b1;
    tick();
    rand_read();
    tick();

    // 6: last beat into bank 1 together with release of bank 0
    apply_reset();
    load(mk(1), 0, NB-1, 1'b0);
    load(mk(2), 0, NB-2, 1'b0);
    rhs_start = 1'b1;
    rhs_data  = beat_of(mk(2), NB-1);
    done      = 1'b1;
    tick();
    rand_read();
    tick();
    load(mk(3), 0, 0, 1'b1);

    // Randomized phase
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      rhs_start = 1'($urandom_range(0, 1));
      for (int j = 0; j < (RPB*N*W)/32; j++) rhs_data[j*32 +: 32] = $urandom;
      if ($urandom_range(0, 2) != 0) rand_read();
      done = ($urandom_range(0, 7) == 0);
      keep = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
